irrigacao_seq: RTL
==================

# irrigacao_seq

Clocked sequencer for the irrigation/reservoir datapath. It debounces the tank level probes (H, M, L) and decodes the level. It drives the inlet valve with fill hysteresis. It grants the single pump to either drip (Vs) or sprinkler (Bs) through a state machine with minimum run time, timeout and cooldown. It replaces direct combinational valve drive and sits between the sensor pins and the valve/alarm drivers.

## Interface
- DEB_CYC, 4: consecutive identical samples required to accept a new level code (≥2)
- MIN_ON, 16: minimum cycles a valve stays open once granted (≥1)
- MAX_ON, 64: maximum run cycles before forced stop (> MIN_ON)
- PAUSE, 8: cooldown cycles with both valves closed after any run (≥1)
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- H, M, L  in  1 each  level probes (high/mid/low), raw, asynchronous to clk
- Us  in  1  soil moisture, 1 = wet
- Ua  in  1  air humidity, 1 = humid
- T  in  1  temperature, 1 = hot
- Vs  out  1  drip valve
- Bs  out  1  sprinkler valve
- Ve  out  1  inlet valve
- Al  out  1  alarm
- Erro  out  1  invalid probe code
- Nivel  out  2  decoded level: 0 Vazio, 1 Baixo, 2 Medio, 3 Cheio
- Estado  out  3  FSM state encoding (see Operation)

## Operation
- Debounce: {H,M,L} passes through a 2-flop synchronizer. A code held constant for DEB_CYC consecutive synchronized samples loads into lvl. The flag ok sets on the first load and clears only on rst.
- Decode lvl: 000 Vazio, 001 Baixo, 011 Medio, 111 Cheio. Any other code gives Erro=1, and Nivel holds its last valid value.
- Before ok: Ve=Vs=Bs=Al=Erro=0, Nivel=0, FSM held in IDLE.
- Ve (hysteresis): sets on Vazio or Baixo, clears on Cheio, holds on Medio. Forced 0 while Erro.
- FSM states: IDLE=0, GOTEJA=1, ASPERSAO=2, PAUSA=3, FALHA=4.
- IDLE: Erro → FALHA. Otherwise, with Us=0 and level ≠ Vazio:
  - Ua=0 → ASPERSAO
  - Ua=1 & T=1 → GOTEJA
  - Ua=1 & T=0 & Baixo → GOTEJA
  - Ua=1 & T=0 & (Medio|Cheio) → ASPERSAO
  - Otherwise stay in IDLE.
- GOTEJA/ASPERSAO: the run counter starts at 0 on entry. Mode is fixed for the whole run; input changes never switch valves mid-run.
  - Erro → FALHA immediately, ignoring MIN_ON.
  - Vazio → PAUSA immediately, ignoring MIN_ON.
  - cnt ≥ MIN_ON-1 and Us=1 → PAUSA, and Tout clears.
  - cnt = MAX_ON-1 → PAUSA, and Tout sets.
- PAUSA: runs PAUSE cycles, then → IDLE. Erro → FALHA.
- FALHA: all valves 0. When Erro=0 → PAUSA.
- Vs=1 only in GOTEJA. Bs=1 only in ASPERSAO. Never both.
- Al = Erro | Vazio | Baixo | Tout (after ok). Tout is sticky until a run ends on Us=1, or rst.
- Counters are sized for their maximum parameter value. The run counter never wraps, because MAX_ON always terminates the run first.

## Timing
- All outputs are registered.
- Reset values: Vs=Bs=Ve=Al=Erro=0, Nivel=0, Estado=0 (IDLE), Tout=0, ok=0, all counters 0.
- Level latency: a pin change is seen in synchronized form 2 edges later. It loads into lvl at the DEB_CYC-th identical sample. Ve/Al/Erro/Nivel update 1 edge after that.
- Bounce: any differing sample restarts the debounce count, and lvl is unchanged.
- FSM: the state decision uses the current-cycle lvl/Us/Ua/T. The valve output changes on the same edge as the state change.
- Run length with Us going 1 early: exactly MIN_ON cycles of valve high. Timeout run: exactly MAX_ON cycles. The PAUSA window is exactly PAUSE cycles of both valves low.
- Simultaneous Erro and timeout in the same cycle: Erro wins, FSM → FALHA, and Tout is not set.
- Simultaneous Vazio and timeout: → PAUSA, and Tout sets.
- rst mid-run: the next edge closes all valves, returns to IDLE and clears ok. Debounce restarts from scratch.

## Test plan
- Reset, then hold {H,M,L}=011: Ve=0 and Nivel=0 until ok. At edge 2+4+1 after release, Nivel=2, Ve=0, Al=0.
- Medio, Us=0, Ua=0, then Us=1 after 3 cycles: Bs high exactly 16 cycles, then 8 cycles of PAUSA, then IDLE. Vs stays 0 throughout.
- Baixo, Us=0, Ua=1, T=0, Us held 0: Vs high exactly 64 cycles. Tout and Al=1. A later run ended by Us=1 clears Tout.
- During GOTEJA at cycle 5, switch the probes to 101 (stable for 4 samples): FSM → FALHA with Vs=0, Erro=1, Al=1. Restoring 001 gives FALHA → PAUSA (8 cycles) → IDLE.
- Probe toggling 011/001 every 2 cycles: lvl never changes, and Nivel/Ve hold. Fill sequence 000→001→011→111: Ve=1 from Vazio until Cheio, then 0. Dropping to Medio leaves Ve=0.
- Assert rst on cycle 10 of ASPERSAO: the next edge has Bs=0, Estado=0 and all outputs 0.

Source files
------------

// File: rtl/irrigacao_seq.sv
// Irrigation sequencer: debounced probe decode, inlet hysteresis and single-pump drip/sprinkler arbitration.
// Every output is registered; level changes reach the outputs 2 + DEB_CYC + 1 edges after the pins move.
module irrigacao_seq #(
    parameter int DEB_CYC = 4,
    parameter int MIN_ON  = 16,
    parameter int MAX_ON  = 64,
    parameter int PAUSE   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       H,
    input  logic       M,
    input  logic       L,
    input  logic       Us,
    input  logic       Ua,
    input  logic       T,
    output logic       Vs,
    output logic       Bs,
    output logic       Ve,
    output logic       Al,
    output logic       Erro,
    output logic [1:0] Nivel,
    output logic [2:0] Estado
);
    localparam int DW   = $clog2(DEB_CYC + 1);
    localparam int CMAX = (MAX_ON > PAUSE) ? MAX_ON : PAUSE;
    localparam int CW   = $clog2(CMAX);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GOTEJA   = 3'd1,
        ASPERSAO = 3'd2,
        PAUSA    = 3'd3,
        FALHA    = 3'd4
    } state_t;

    logic [2:0]    sync1_q, sync2_q, prev_q, prev_d, lvl_q, lvl_d;
    logic [1:0]    svld_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic          ok_q, ok_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tout_q, tout_d;
    logic          vs_q, vs_d, bs_q, bs_d, ve_q, ve_d, al_q, al_d, erro_q, erro_d;
    logic [1:0]    nivel_q, nivel_d;

    logic          code_ok, err, vazio, baixo, cheio;
    logic [1:0]    dec;

    // The synchronizer's reset contents are not a real sample, so counting waits until it has filled.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        prev_d    = prev_q;
        lvl_d     = lvl_q;
        ok_d      = ok_q;
        if (svld_q[1]) begin
            prev_d = sync2_q;
            if (deb_cnt_q != '0 && sync2_q == prev_q) begin
                if (deb_cnt_q != DW'(DEB_CYC))
                    deb_cnt_d = deb_cnt_q + DW'(1);
            end else begin
                deb_cnt_d = DW'(1);
            end
            if (deb_cnt_d == DW'(DEB_CYC)) begin
                lvl_d = sync2_q;
                ok_d  = 1'b1;
            end
        end
    end

    always_comb begin
        code_ok = 1'b1;
        dec     = 2'd0;
        case (lvl_q)
            3'b000:  dec = 2'd0;
            3'b001:  dec = 2'd1;
            3'b011:  dec = 2'd2;
            3'b111:  dec = 2'd3;
            default: code_ok = 1'b0;
        endcase
        err   = ok_q & ~code_ok;
        vazio = ok_q & code_ok & (dec == 2'd0);
        baixo = ok_q & code_ok & (dec == 2'd1);
        cheio = ok_q & code_ok & (dec == 2'd3);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tout_d  = tout_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (ok_q) begin
                    if (err)
                        state_d = FALHA;
                    else if (!Us && !vazio) begin
                        if (!Ua)
                            state_d = ASPERSAO;
                        else if (T || baixo)
                            state_d = GOTEJA;
                        else
                            state_d = ASPERSAO;
                    end
                end
            end
            GOTEJA, ASPERSAO: begin
                // Priority: fault, empty tank, satisfied soil, then the run timeout.
                if (err) begin
                    state_d = FALHA;
                    cnt_d   = '0;
                end else if (vazio) begin
                    state_d = PAUSA;
                    cnt_d   = '0;
                    if (cnt_q == CW'(MAX_ON - 1))
                        tout_d = 1'b1;
                end else if (cnt_q >= CW'(MIN_ON - 1) && Us) begin
                    state_d = PAUSA;
                    cnt_d   = '0;
                    tout_d  = 1'b0;
                end else if (cnt_q == CW'(MAX_ON - 1)) begin
                    state_d = PAUSA;
                    cnt_d   = '0;
                    tout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PAUSA: begin
                if (err) begin
                    state_d = FALHA;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(PAUSE - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FALHA: begin
                cnt_d = '0;
                if (!err)
                    state_d = PAUSA;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        vs_d   = (state_d == GOTEJA);
        bs_d   = (state_d == ASPERSAO);
        erro_d = err;
        al_d   = ok_q & (err | vazio | baixo | tout_d);
        nivel_d = (ok_q && code_ok) ? dec : nivel_q;
        ve_d   = ve_q;
        if (!ok_q || err)
            ve_d = 1'b0;
        else if (vazio || baixo)
            ve_d = 1'b1;
        else if (cheio)
            ve_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            svld_q    <= '0;
            prev_q    <= '0;
            deb_cnt_q <= '0;
            lvl_q     <= '0;
            ok_q      <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            tout_q    <= 1'b0;
            vs_q      <= 1'b0;
            bs_q      <= 1'b0;
            ve_q      <= 1'b0;
            al_q      <= 1'b0;
            erro_q    <= 1'b0;
            nivel_q   <= 2'd0;
        end else begin
            sync1_q   <= {H, M, L};
            sync2_q   <= sync1_q;
            svld_q    <= {svld_q[0], 1'b1};
            prev_q    <= prev_d;
            deb_cnt_q <= deb_cnt_d;
            lvl_q     <= lvl_d;
            ok_q      <= ok_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tout_q    <= tout_d;
            vs_q      <= vs_d;
            bs_q      <= bs_d;
            ve_q      <= ve_d;
            al_q      <= al_d;
            erro_q    <= erro_d;
            nivel_q   <= nivel_d;
        end
    end

    assign Vs     = vs_q;
    assign Bs     = bs_q;
    assign Ve     = ve_q;
    assign Al     = al_q;
    assign Erro   = erro_q;
    assign Nivel  = nivel_q;
    assign Estado = state_q;
endmodule
